// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader; keep depth in step with imem.
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte index counter and little-endian word assembly for the imem loader.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  idx;
    logic [23:0] asm_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx   <= 2'd0;
            asm_q <= 24'd0;
        end else if (take) begin
            case (idx)
                2'd0:    asm_q[7:0]   <= byte_data;
                2'd1:    asm_q[15:8]  <= byte_data;
                2'd2:    asm_q[23:16] <= byte_data;
                default: ;
            endcase
            idx <= idx + 2'd1;
        end
    end

    // The top byte is never stored: the word is consumed in the same cycle it completes.
    assign word_full = take && (idx == 2'd3);
    assign word      = {byte_data, asm_q};

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program into imem and holds the CPU until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = IMEM_DEPTH,
    parameter int ADDR_W    = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] widx;
    logic [31:0]       pk_word;
    logic              word_full;
    logic              take;
    logic              start_ok;
    logic              count_bad;
    logic              last_word;

    assign take      = byte_valid && byte_ready;
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign count_bad = (word_count == '0) || (word_count > DEPTH_V);
    assign last_word = ({1'b0, widx} == (count_q - 1'b1));

    imem_loader_byte_packer u_byte_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .take      (take),
        .byte_data (byte_data),
        .word      (pk_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_nxt = count_bad ? IDLE : LOAD;
            end
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_full) state_nxt = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                state_nxt = last_word ? DONE : LOAD;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nxt = count_bad ? IDLE : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data are registered on the 4th byte so they are stable through WRITE and after.
    always_ff @(posedge clk) begin
        if (reset) begin
            err       <= 1'b0;
            count_q   <= '0;
            widx      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (start_ok) begin
                if (count_bad) begin
                    err <= 1'b1;
                end else begin
                    err     <= 1'b0;
                    count_q <= word_count;
                    widx    <= '0;
                end
            end
            if (state == LOAD && word_full) begin
                mem_addr  <= widx;
                mem_wdata <= pk_word;
            end
            if (state == WRITE && !last_word) widx <= widx + 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: handshake, write timing, count checks and reset recovery.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int base;
    logic [31:0] tbmem [64];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behaves like the imem array: captures every write strobe.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            tbmem[mem_addr] <= mem_wdata;
            wr_cnt          <= wr_cnt + 1;
        end
    end

    function automatic logic [31:0] img(input int n);
        return ((32'(n) + 32'd1) * 32'h9E3779B9) ^ 32'h0F0F0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [6:0] wc);
        start      = 1'b1;
        word_count = wc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_ready_wait", 32'(byte_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic load_word(input logic [5:0] addr, input logic [31:0] w, input bit stall);
        for (int k = 0; k < 4; k++) begin
            push(w[8*k +: 8]);
            if (stall && k < 3) begin
                byte_valid = 1'b0;
                byte_data  = 8'hEE;
                @(negedge clk);
                check("stall_no_we", 32'(mem_we), 32'd0);
                @(negedge clk);
            end
        end
        byte_valid = 1'b0;
        check("write_we", 32'(mem_we), 32'd1);
        check("write_addr", 32'(mem_addr), 32'(addr));
        check("write_data", mem_wdata, w);
        check("write_ready_low", 32'(byte_ready), 32'd0);
        @(negedge clk);
        check("we_one_cycle", 32'(mem_we), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // single word
        base = wr_cnt;
        do_start(7'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_hold", 32'(cpu_hold), 32'd1);
        check("t1_ready", 32'(byte_ready), 32'd1);
        load_word(6'd0, 32'h12345678, 1'b0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold_rel", 32'(cpu_hold), 32'd0);
        check("t1_busy_clr", 32'(busy), 32'd0);
        check("t1_ready_low", 32'(byte_ready), 32'd0);
        check("t1_writes", 32'(wr_cnt - base), 32'd1);

        // stalled source, restart from DONE
        base = wr_cnt;
        do_start(7'd2);
        load_word(6'd0, 32'hA1B2C3D4, 1'b1);
        check("t2_busy_mid", 32'(busy), 32'd1);
        load_word(6'd1, 32'h0BADF00D, 1'b1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_addr_hold", 32'(mem_addr), 32'd1);
        check("t2_data_hold", mem_wdata, 32'h0BADF00D);
        check("t2_mem0", tbmem[0], 32'hA1B2C3D4);
        check("t2_writes", 32'(wr_cnt - base), 32'd2);

        // rejected counts
        base = wr_cnt;
        do_start(7'd0);
        check("t3_err0", 32'(err), 32'd1);
        check("t3_done0", 32'(done), 32'd0);
        check("t3_hold0", 32'(cpu_hold), 32'd1);
        check("t3_busy0", 32'(busy), 32'd0);
        do_start(7'd65);
        check("t3_err65", 32'(err), 32'd1);
        byte_valid = 1'b1; byte_data = 8'h99;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        check("t3_ready_low", 32'(byte_ready), 32'd0);
        check("t3_no_write", 32'(wr_cnt - base), 32'd0);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        do_start(7'd3);
        check("t3_err_clr", 32'(err), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        for (int n = 0; n < 3; n++) load_word(6'(n), img(n + 100), 1'b0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_writes", 32'(wr_cnt - base), 32'd3);

        // start during load is ignored
        base = wr_cnt;
        do_start(7'd2);
        load_word(6'd0, 32'h55667788, 1'b0);
        do_start(7'd5);
        check("t4_busy", 32'(busy), 32'd1);
        load_word(6'd1, 32'h99AABBCC, 1'b0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_writes", 32'(wr_cnt - base), 32'd2);

        // reset after two bytes of word 1
        do_start(7'd2);
        base = wr_cnt;
        load_word(6'd0, 32'h11223344, 1'b0);
        push(8'hAA);
        push(8'hBB);
        byte_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_ready", 32'(byte_ready), 32'd0);
        check("t5_hold", 32'(cpu_hold), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_addr", 32'(mem_addr), 32'd0);
        check("t5_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        check("t5_writes", 32'(wr_cnt - base), 32'd1);
        check("t5_mem0", tbmem[0], 32'h11223344);
        do_start(7'd1);
        load_word(6'd0, 32'hCAFEBABE, 1'b0);
        check("t5_reload_done", 32'(done), 32'd1);

        // full image
        base = wr_cnt;
        do_start(7'd64);
        for (int n = 0; n < 64; n++) load_word(6'(n), img(n), 1'b0);
        check("t6_done", 32'(done), 32'd1);
        check("t6_hold", 32'(cpu_hold), 32'd0);
        check("t6_writes", 32'(wr_cnt - base), 32'd64);
        for (int n = 0; n < 64; n++) check("t6_image", tbmem[n], img(n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory; the fetch path (pc -> imem -> instruction register) is the reader side.
- Accepts a program as a byte stream with a valid/ready handshake and assembles 32-bit little-endian words.
- Issues one write per word into imem at consecutive word addresses starting at 0.
- Holds the processor in reset until the whole program is written, so fetch never reads a partially loaded image.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in imem.
- ADDR_W, 6, word address width; equals clog2(MEM_DEPTH).

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- word_count  in  ADDR_W+1  number of words to load; sampled on the accepted start.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  program byte; a word's least significant byte arrives first.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  imem write strobe, one cycle per word.
- mem_addr  out  ADDR_W  imem word address.
- mem_wdata  out  32  assembled word.
- cpu_hold  out  1  active-high hold or reset to the processor.
- busy  out  1  a load is in progress.
- done  out  1  sticky: load completed.
- err  out  1  sticky: rejected word_count.

Behaviour:
- Reset values: state IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, err=0. Byte index and word index are both 0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE or DONE, start=1:
  - If word_count==0 or word_count>MEM_DEPTH: err=1 and done=0, go to IDLE, cpu_hold=1.
  - Otherwise latch word_count, clear err, done, byte index and word index. Set cpu_hold=1 and busy=1, go to LOAD.
- LOAD:
  - byte_ready=1.
  - A byte is accepted only on a cycle with byte_valid & byte_ready.
  - Byte index k (0..3) is written into word bits [8k+7:8k]; the index then increments.
  - When the 4th byte is accepted, go to WRITE and reset the byte index to 0.
  - byte_valid=0 means the loader waits indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word index, mem_wdata=assembled word, byte_ready=0.
  - Latency: mem_we is asserted in the cycle immediately after the 4th byte handshake.
  - If word index == latched count-1, go to DONE; otherwise increment word index and return to LOAD.
- DONE: done=1, busy=0, cpu_hold=0, byte_ready=0. The loader stays in DONE until reset or a new start.
- Outside WRITE, mem_we=0. mem_addr and mem_wdata hold their last values, so no glitches reach imem.
- start while busy (LOAD or WRITE) is ignored; the latched count is not altered.
- start while IDLE with err=1 is evaluated normally; a valid count clears err.
- Reset mid-load: return to IDLE with all outputs at reset values. The partial word is discarded and no write is issued. Words already written remain in imem.
- Word index never wraps: the count check guarantees word index ≤ MEM_DEPTH-1.
- Bytes offered while byte_ready=0 are not consumed; the source must hold them.

Decomposition:
- Shared package: the state enum (IDLE, LOAD, WRITE, DONE) and the MEM_DEPTH/ADDR_W defaults, kept consistent with imem.
- One natural sub-module, byte_packer: byte index counter plus 32-bit shift/assemble register, with a word_full output. The FSM and word counter stay in imem_loader.

Test Plan:
- Single-word load: reset, start with word_count=1, bytes 0x78,0x56,0x34,0x12 on consecutive cycles.
  -> mem_we for exactly one cycle, one cycle after the 4th byte, with mem_addr=0 and mem_wdata=0x12345678. Then done=1, cpu_hold=0, busy=0.
- Full image: word_count=64, bytes taken from memfile.dat words.
  -> 64 writes at addresses 0..63 in order. The fetch chain then reads RAM[n] equal to file word n.
- Stalled source: word_count=2 with byte_valid toggling 1,0,0,1,...
  -> Only valid&ready bytes are consumed and words are unchanged. byte_ready=0 during each WRITE cycle.
- Bad count: start with word_count=0, then with word_count=65.
  -> err=1, no mem_we, cpu_hold=1. A later start with word_count=3 clears err and loads normally.
- Reset mid-load: assert reset after 2 bytes of word 1.
  -> No write for the partial word, state IDLE, cpu_hold=1, done=0. Word 0 already written is unaffected.
- start during load: pulse start with word_count=5 during LOAD of a 2-word load.
  -> Ignored; exactly 2 writes, then done.
